// File: rtl/fp16_mac_pe_multislot.sv
// rtl/fp16_mac_pe_multislot.sv - pipelined FP16 MAC PE with ACC_DEPTH accumulator slots and drain FSM
// Optional per-slot Inf/NaN sticky flag and res_exc port when FP16_MAC_EXC_FLAG_EN is defined.

module fp16_approximate_multiplier #(
    parameter int APPROX_BITS = 10
) (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] p_o
);
    // APPROX_BITS keeps that many upper fraction bits of each operand
    localparam int DROP = 10 - APPROX_BITS;
    localparam logic [9:0] MASK = 10'(~((1 << DROP) - 1));

    logic [4:0]  ea, eb;
    logic [10:0] ma, mb;
    logic [21:0] p;
    logic [11:0] r;
    logic [7:0]  e;
    logic        sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    always_comb begin
        ea     = a_i[14:10];
        eb     = b_i[14:10];
        sgn    = a_i[15] ^ b_i[15];
        a_zero = (ea == 5'h00);
        b_zero = (eb == 5'h00);
        a_inf  = (ea == 5'h1F) && (a_i[9:0] == 10'h0);
        b_inf  = (eb == 5'h1F) && (b_i[9:0] == 10'h0);
        a_nan  = (ea == 5'h1F) && (a_i[9:0] != 10'h0);
        b_nan  = (eb == 5'h1F) && (b_i[9:0] != 10'h0);
        ma     = {1'b1, a_i[9:0] & MASK};
        mb     = {1'b1, b_i[9:0] & MASK};
        p      = 22'(ma) * 22'(mb);
        r      = '0;
        e      = '0;
        p_o    = 16'h0000;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p_o = 16'h7E00;
        end else if (a_inf || b_inf) begin
            p_o = {sgn, 5'h1F, 10'h0};
        end else if (!a_zero && !b_zero) begin
            if (p[21]) r = {1'b0, p[21:11]} + {11'b0, p[10]};
            else       r = {1'b0, p[20:10]} + {11'b0, p[9]};
            e = 8'(ea) + 8'(eb) - 8'd15 + {7'b0, p[21]} + {7'b0, r[11]};
            if (e[7] || e == 8'd0)  p_o = 16'h0000;
            else if (e >= 8'd31)    p_o = {sgn, 5'h1F, 10'h0};
            else                    p_o = {sgn, e[4:0], r[11] ? 10'h0 : r[9:0]};
        end
    end
endmodule

module fp16_approximate_adder #(
    parameter int APPROX_ALIGN = 31
) (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);
    logic [15:0] big, sml;
    logic [4:0]  eb, lz;
    logic [13:0] mb, ms, ms_sh, norm;
    logic [14:0] s;
    logic [5:0]  d;
    logic [11:0] r;
    logic [7:0]  e;
    logic        found;

    always_comb begin
        big   = (a_i[14:0] >= b_i[14:0]) ? a_i : b_i;
        sml   = (a_i[14:0] >= b_i[14:0]) ? b_i : a_i;
        eb    = big[14:10];
        mb    = {1'b1, big[9:0], 3'b000};
        ms    = {1'b1, sml[9:0], 3'b000};
        d     = {1'b0, eb} - {1'b0, sml[14:10]};
        // shifts beyond the alignment window drop the smaller operand entirely
        ms_sh = (int'(d) > APPROX_ALIGN) ? 14'h0 : (ms >> d);
        s     = (big[15] == sml[15]) ? ({1'b0, mb} + {1'b0, ms_sh}) : ({1'b0, mb} - {1'b0, ms_sh});
        lz    = '0;
        found = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            if (!found && s[i]) begin
                lz    = 5'(13 - i);
                found = 1'b1;
            end
        end
        norm  = s[14] ? s[14:1] : (s[13:0] << lz);
        r     = {1'b0, norm[13:3]} + {11'b0, norm[2]};
        e     = s[14] ? (8'(eb) + 8'd1) : (8'(eb) - 8'(lz));
        e     = e + {7'b0, r[11]};
        sum_o = 16'h0000;
        if (a_i[14:10] == 5'h1F) begin
            sum_o = a_i;
        end else if (b_i[14:10] == 5'h1F) begin
            sum_o = b_i;
        end else if (a_i[14:10] == 5'h00) begin
            sum_o = (b_i[14:10] == 5'h00) ? 16'h0000 : b_i;
        end else if (b_i[14:10] == 5'h00) begin
            sum_o = a_i;
        end else if (s != 15'h0) begin
            if (e[7] || e == 8'd0)  sum_o = 16'h0000;
            else if (e >= 8'd31)    sum_o = {big[15], 5'h1F, 10'h0};
            else                    sum_o = {big[15], e[4:0], r[11] ? 10'h0 : r[9:0]};
        end
    end
endmodule

module fp16_mac_pe_multislot #(
    parameter int MULT_APPROX_BITS = 10,
    parameter int ADD_APPROX_ALIGN = 31,
    parameter int ACC_DEPTH        = 4,
    parameter int SLOT_W           = $clog2(ACC_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              in_valid,
    input  logic              acc_clear,
    input  logic [SLOT_W-1:0] slot_in,
    input  logic [15:0]       a_in,
    input  logic [15:0]       w_in,
    input  logic              drain_req,
    output logic [15:0]       a_out,
    output logic [15:0]       w_out,
    output logic              valid_out,
    output logic              clear_out,
    output logic [SLOT_W-1:0] slot_out,
    output logic              busy,
    output logic              res_valid,
    output logic [SLOT_W-1:0] res_slot,
    output logic [15:0]       res_data,
    output logic              drop_err
`ifdef FP16_MAC_EXC_FLAG_EN
   ,output logic              res_exc
`endif
);
    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(ACC_DEPTH - 1);

    state_t            state_q, state_d;
    logic [15:0]       a_out_q, w_out_q;
    logic              valid_out_q, clear_out_q;
    logic [SLOT_W-1:0] slot_out_q;
    logic [15:0]       s1_prod_q;
    logic              s1_valid_q, s1_clear_q;
    logic [SLOT_W-1:0] s1_slot_q;
    logic [15:0]       acc_q [ACC_DEPTH];
    logic [SLOT_W-1:0] idx_q;
    logic              res_valid_q;
    logic [SLOT_W-1:0] res_slot_q;
    logic [15:0]       res_data_q;
    logic              drop_err_q;
    logic [15:0]       mul_p, add_sum, wr_val;
    logic              accept, drain_active, busy_c;

    fp16_approximate_multiplier #(.APPROX_BITS(MULT_APPROX_BITS)) u_mul (
        .a_i (a_in),
        .b_i (w_in),
        .p_o (mul_p)
    );

    fp16_approximate_adder #(.APPROX_ALIGN(ADD_APPROX_ALIGN)) u_add (
        .a_i   (acc_q[s1_slot_q]),
        .b_i   (s1_prod_q),
        .sum_o (add_sum)
    );

    assign wr_val = s1_clear_q ? s1_prod_q : add_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      state_q <= RUN;
        else if (enable) state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_req) state_d = FLUSH;
            FLUSH:   state_d = DRAIN;
            DRAIN:   if (idx_q == LAST_SLOT) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        accept       = (state_q == RUN) && in_valid;
        drain_active = (state_q == DRAIN);
        busy_c       = (state_q != RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out_q     <= '0;
            w_out_q     <= '0;
            valid_out_q <= 1'b0;
            clear_out_q <= 1'b0;
            slot_out_q  <= '0;
            s1_prod_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_clear_q  <= 1'b0;
            s1_slot_q   <= '0;
            idx_q       <= '0;
            res_valid_q <= 1'b0;
            res_slot_q  <= '0;
            res_data_q  <= '0;
            drop_err_q  <= 1'b0;
            for (int i = 0; i < ACC_DEPTH; i++) acc_q[i] <= '0;
        end else if (enable) begin
            a_out_q     <= a_in;
            w_out_q     <= w_in;
            valid_out_q <= in_valid;
            clear_out_q <= acc_clear;
            slot_out_q  <= slot_in;
            s1_valid_q  <= accept;
            if (accept) begin
                s1_prod_q  <= mul_p;
                s1_clear_q <= acc_clear;
                s1_slot_q  <= slot_in;
            end
            if (in_valid && busy_c) drop_err_q <= 1'b1;
            res_valid_q <= drain_active;
            if (state_q == FLUSH) idx_q <= '0;
            // stage 2 is always idle during DRAIN: FLUSH retires the last product
            if (drain_active) begin
                res_data_q   <= acc_q[idx_q];
                res_slot_q   <= idx_q;
                acc_q[idx_q] <= '0;
                idx_q        <= (idx_q == LAST_SLOT) ? '0 : idx_q + 1'b1;
            end else if (s1_valid_q) begin
                acc_q[s1_slot_q] <= wr_val;
            end
        end
    end

`ifdef FP16_MAC_EXC_FLAG_EN
    logic [ACC_DEPTH-1:0] exc_q;
    logic                 res_exc_q;
    logic                 wr_exc;

    assign wr_exc = (wr_val[14:10] == 5'h1F);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_q     <= '0;
            res_exc_q <= 1'b0;
        end else if (enable) begin
            if (drain_active) begin
                res_exc_q    <= exc_q[idx_q];
                exc_q[idx_q] <= 1'b0;
            end else if (s1_valid_q) begin
                exc_q[s1_slot_q] <= s1_clear_q ? wr_exc : (exc_q[s1_slot_q] | wr_exc);
            end
        end
    end

    assign res_exc = res_exc_q;
`endif

    assign a_out     = a_out_q;
    assign w_out     = w_out_q;
    assign valid_out = valid_out_q;
    assign clear_out = clear_out_q;
    assign slot_out  = slot_out_q;
    assign busy      = busy_c;
    assign res_valid = res_valid_q;
    assign res_slot  = res_slot_q;
    assign res_data  = res_data_q;
    assign drop_err  = drop_err_q;
endmodule

// File: tb/tb_fp16_mac_pe_multislot.sv
// tb/tb_fp16_mac_pe_multislot.sv - directed self-checking bench for fp16_mac_pe_multislot

module tb_fp16_mac_pe_multislot;
    logic        clk = 1'b0;
    logic        rst_n, enable, in_valid, acc_clear, drain_req;
    logic [1:0]  slot_in;
    logic [15:0] a_in, w_in;
    logic [15:0] a_out, w_out, res_data;
    logic        valid_out, clear_out, busy, res_valid, drop_err;
    logic [1:0]  slot_out, res_slot;
`ifdef FP16_MAC_EXC_FLAG_EN
    logic        res_exc;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_d [4];
    logic        exp_x [4];

    always #5 clk = ~clk;

    fp16_mac_pe_multislot dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .acc_clear (acc_clear),
        .slot_in   (slot_in),
        .a_in      (a_in),
        .w_in      (w_in),
        .drain_req (drain_req),
        .a_out     (a_out),
        .w_out     (w_out),
        .valid_out (valid_out),
        .clear_out (clear_out),
        .slot_out  (slot_out),
        .busy      (busy),
        .res_valid (res_valid),
        .res_slot  (res_slot),
        .res_data  (res_data),
        .drop_err  (drop_err)
`ifdef FP16_MAC_EXC_FLAG_EN
       ,.res_exc   (res_exc)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic c, input logic [1:0] s, input logic [15:0] a, input logic [15:0] w);
        in_valid  = v;
        acc_clear = c;
        slot_in   = s;
        a_in      = a;
        w_in      = w;
    endtask

    // Pulses drain_req with whatever input is currently presented, then checks the 4-slot stream.
    task automatic run_drain(input int stall_at, input bit inject);
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        in_valid  = 1'b0;
        acc_clear = 1'b0;
        chk("busy_flush", busy, 1);
        chk("rv_flush", res_valid, 0);
        step();
        chk("busy_drain_start", busy, 1);
        chk("rv_drain_start", res_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_rv", res_valid, 1);
            chk("drain_slot", res_slot, i);
            chk("drain_data", res_data, exp_d[i]);
`ifdef FP16_MAC_EXC_FLAG_EN
            chk("drain_exc", res_exc, exp_x[i]);
`endif
            if (i < 3) chk("drain_busy", busy, 1);
            if (inject && i == 0) set_in(1'b1, 1'b1, 2'd3, 16'h1234, 16'hABCD);
            if (inject && i == 1) begin
                chk("fwd_busy_a", a_out, 16'h1234);
                chk("fwd_busy_w", w_out, 16'hABCD);
                chk("fwd_busy_slot", slot_out, 3);
                chk("fwd_busy_valid", valid_out, 1);
                chk("drop_err_set", drop_err, 1);
                set_in(1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
            end
            if (i == stall_at) begin
                enable = 1'b0;
                repeat (3) begin
                    step();
                    chk("stall_rv", res_valid, 1);
                    chk("stall_slot", res_slot, i);
                    chk("stall_data", res_data, exp_d[i]);
                    chk("stall_busy", busy, 1);
                end
                enable = 1'b1;
            end
        end
        chk("busy_fall", busy, 0);
        step();
        chk("rv_end", res_valid, 0);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b1;
        drain_req = 1'b0;
        set_in(1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) exp_x[i] = 1'b0;
        repeat (2) step();
        chk("rst_a_out", a_out, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_drop_err", drop_err, 0);
        rst_n = 1'b1;
        step();

        // slot0: 1*2 then +1*2 = 4.0 ; slot1: 2*3 = 6.0
        set_in(1'b1, 1'b1, 2'd0, 16'h3C00, 16'h4000);
        step();
        chk("fwd_a", a_out, 16'h3C00);
        chk("fwd_w", w_out, 16'h4000);
        chk("fwd_valid", valid_out, 1);
        chk("fwd_clear", clear_out, 1);
        chk("fwd_slot0", slot_out, 0);
        set_in(1'b1, 1'b0, 2'd0, 16'h3C00, 16'h4000);
        step();
        chk("fwd_clear0", clear_out, 0);
        set_in(1'b1, 1'b1, 2'd1, 16'h4000, 16'h4200);
        step();
        chk("fwd_slot1", slot_out, 1);
        set_in(1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
        step();
        step();
        exp_d[0] = 16'h4400; exp_d[1] = 16'h4600; exp_d[2] = 16'h0000; exp_d[3] = 16'h0000;
        run_drain(-1, 1'b0);
        chk("drop_err_clean", drop_err, 0);

        // second drain returns zeros; input presented mid-drain must be dropped
        for (int i = 0; i < 4; i++) exp_d[i] = 16'h0000;
        run_drain(-1, 1'b1);
        chk("drop_err_after", drop_err, 1);
        repeat (3) step();
        chk("drop_err_sticky", drop_err, 1);

        // enable low mid-stream: held input must not be accumulated repeatedly
        set_in(1'b1, 1'b1, 2'd3, 16'h3C00, 16'h4000);
        step();
        enable = 1'b0;
        set_in(1'b1, 1'b0, 2'd3, 16'h4000, 16'h3C00);
        repeat (3) begin
            step();
            chk("frz_a_out", a_out, 16'h3C00);
            chk("frz_clear_out", clear_out, 1);
            chk("frz_valid_out", valid_out, 1);
        end
        enable = 1'b1;
        step();
        chk("resume_a_out", a_out, 16'h4000);
        chk("resume_clear_out", clear_out, 0);
        set_in(1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
        step();
        step();
        // same-edge drain_req and input into slot 2, with a stall mid-drain
        set_in(1'b1, 1'b1, 2'd2, 16'h3C00, 16'h3C00);
        exp_d[0] = 16'h0000; exp_d[1] = 16'h0000; exp_d[2] = 16'h3C00; exp_d[3] = 16'h4400;
        run_drain(2, 1'b0);
        chk("drop_err_hold", drop_err, 1);

`ifdef FP16_MAC_EXC_FLAG_EN
        set_in(1'b1, 1'b1, 2'd1, 16'h7BFF, 16'h7BFF);
        step();
        set_in(1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
        step();
        step();
        for (int i = 0; i < 4; i++) exp_d[i] = 16'h0000;
        exp_d[1] = 16'h7C00;
        exp_x[1] = 1'b1;
        run_drain(-1, 1'b0);
        exp_x[1] = 1'b0;
`endif

        // reset during drain cycle 2 aborts and zeroes undrained slots
        set_in(1'b1, 1'b1, 2'd0, 16'h3C00, 16'h3C00);
        step();
        set_in(1'b1, 1'b1, 2'd3, 16'h4000, 16'h4000);
        step();
        set_in(1'b0, 1'b0, 2'd0, 16'h0, 16'h0);
        step();
        step();
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        step();
        step();
        chk("abort_d1_rv", res_valid, 1);
        chk("abort_d1_data", res_data, 16'h3C00);
        step();
        chk("abort_d2_rv", res_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_rv", res_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data", res_data, 0);
        chk("abort_drop_err", drop_err, 0);
        step();
        chk("abort_rv_hold", res_valid, 0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) exp_d[i] = 16'h0000;
        run_drain(-1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp16_mac_pe_multislot.md
Name: fp16_mac_pe_multislot

Overview:
- Parametrised, pipelined FP16 multiply-accumulate processing element for the weight/activation systolic array.
- Next generation of the single-accumulator MAC PE. Adds:
  - a registered two-stage multiply/add pipeline;
  - ACC_DEPTH independent accumulator slots, so several output tiles can be interleaved;
  - valid/slot tags that travel through the array;
  - a self-sequenced drain FSM that streams all slots out and zeroes them.
- Arithmetic reuses the codebase's fp16_approximate_multiplier and fp16_approximate_adder.

Parameters:
- MULT_APPROX_BITS, 10, approximation setting passed to fp16_approximate_multiplier (10 = exact mantissa).
- ADD_APPROX_ALIGN, 31, alignment setting passed to fp16_approximate_adder (31 = exact alignment).
- ACC_DEPTH, 4, number of accumulator slots (power of two, 2..16).
- SLOT_W, $clog2(ACC_DEPTH), slot index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  global advance; when low every register holds, including the FSM.
- in_valid  in  1  a_in/w_in carry a product to accumulate.
- acc_clear  in  1  with in_valid: load the product into the slot instead of adding to it.
- slot_in  in  SLOT_W  target slot.
- a_in, w_in  in  16  FP16 activation and weight.
- drain_req  in  1  pulse: start the drain sequence.
- a_out, w_out  out  16  forwarded operands.
- valid_out, clear_out  out  1  forwarded in_valid and acc_clear.
- slot_out  out  SLOT_W  forwarded slot_in.
- busy  out  1  state != RUN.
- res_valid  out  1  drain result strobe.
- res_slot  out  SLOT_W  index of the drained slot.
- res_data  out  16  drained accumulator value.
- drop_err  out  1  sticky: in_valid was asserted while busy.

Behaviour:
- Reset: all outputs, stage-1 registers, every slot and drain index go to 0; FSM goes to RUN.
- Nothing below happens on an edge where enable=0; all registers hold.
- Forwarding: on every enabled edge, a_out/w_out/valid_out/clear_out/slot_out <= the corresponding inputs, regardless of state.
- Stage 1 (input accepted only in RUN, with in_valid=1):
  - s1_prod <= multiplier(a_in, w_in); s1_valid, s1_clear, s1_slot are captured with it.
  - In any other state, s1_valid <= 0 and in_valid is dropped.
- Stage 2 (when s1_valid=1): acc[s1_slot] <= s1_clear ? s1_prod : adder(acc[s1_slot], s1_prod).
- Latency and hazards:
  - A product is reflected in its slot 2 enabled edges after in_valid is sampled.
  - Back-to-back inputs to the same slot need no forwarding: stage 2 reads and writes in one cycle.
- acc_clear while in_valid=0 has no effect.
- FSM states RUN, FLUSH, DRAIN:
  - RUN + drain_req -> FLUSH. An input sampled on the same edge is still accepted.
  - FLUSH -> DRAIN after 1 enabled cycle; stage 2 retires the last product. Drain index is 0.
  - DRAIN, each enabled edge:
    - res_data <= acc[idx]; res_slot <= idx; res_valid <= 1; acc[idx] <= 0.
    - If idx == ACC_DEPTH-1 -> RUN, otherwise idx++.
  - In every other state, res_valid <= 0.
  - Result: res_valid is high for exactly ACC_DEPTH consecutive enabled cycles, slots in ascending order.
- drain_req in FLUSH or DRAIN is ignored.
- drop_err is set when in_valid=1 while busy; it is cleared only by reset.
- Reset asserted mid-drain aborts immediately: slots are zeroed and no further res_valid is produced.

Optional Feature:
- Macro: FP16_MAC_EXC_FLAG_EN.
- When defined:
  - Per-slot sticky exception bit, set when the value written to the slot has exponent 5'h1F (Inf/NaN).
  - The exception bit is cleared by a clear-load of a non-exceptional value or by draining that slot.
  - Extra output port res_exc (1 bit), registered alongside res_data.
- When undefined: no flags and no res_exc port.

Test Plan:
- Accumulate in slot 0: (3C00,4000,clear=1) then (3C00,4000,clear=0); slot 1: (4000,4200,clear=1); then drain_req. Required:
  - busy rises;
  - res_valid for 4 cycles with (slot0, 4400), (slot1, 4600), (slot2, 0000), (slot3, 0000);
  - busy falls;
  - a second drain returns all zeros.
- Same-edge drain_req and in_valid (3C00,3C00,slot 2,clear=1) -> slot 2 drains as 3C00.
- enable held low 3 cycles mid-stream and mid-drain -> all outputs frozen; the sequence resumes with identical values and no lost or duplicated res_valid.
- in_valid=1 during DRAIN -> drop_err=1 and the input is not accumulated; drop_err stays set until rst_n low.
- Forwarding: a_in=1234, w_in=ABCD, slot_in=3, in_valid=1 -> one enabled cycle later a_out=1234, w_out=ABCD, slot_out=3, valid_out=1, including while busy.
- With FP16_MAC_EXC_FLAG_EN: (7BFF,7BFF,clear=1) into slot 1, then drain -> (slot1, 7C00, res_exc=1). Assert rst_n low during drain cycle 2 -> res_valid=0, busy=0, all slots 0 afterwards.
